// File: rtl/lcd_frame_refresher.sv
// lcd_frame_refresher: HD44780-style character writer backed by a LINES x CHARS frame buffer.
// Upstream logic writes single characters at any time; the engine redraws only dirty lines,
// round-robin, once the LCD initialiser reports init_done.
//
// Ports:
//   clk_i            system clock
//   reset_i          synchronous, active-high reset
//   init_done_i      initialiser finished; engine is held idle while low
//   wr_en_i          frame-buffer write strobe (one char per cycle)
//   wr_line_i        target line
//   wr_col_i         target column, 0 is leftmost
//   wr_char_i        character code
//   force_refresh_i  one-cycle pulse, marks every line dirty
//   lcd_rs_o         register select (0 command, 1 data)
//   lcd_rw_o         always 0 (write-only bus)
//   lcd_e_o          enable strobe
//   lcd_data_o       bus data
//   busy_o           high whenever the engine is not idle
//   frame_done_o     one-cycle pulse when the last dirty line has been written
module lcd_frame_refresher #(
  parameter int unsigned     LINES       = 4,
  parameter int unsigned     CHARS       = 20,
  parameter logic [0:3][6:0] LINE_STARTS = {7'h00, 7'h40, 7'h14, 7'h54},
  parameter int unsigned     SETUP_CYC   = 2,
  parameter int unsigned     E_CYC       = 25,
  parameter int unsigned     WAIT_CYC    = 2500,
  localparam int unsigned    LW          = (LINES > 1) ? $clog2(LINES) : 1,
  localparam int unsigned    CW          = (CHARS > 1) ? $clog2(CHARS) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          init_done_i,
  input  logic          wr_en_i,
  input  logic [LW-1:0] wr_line_i,
  input  logic [CW-1:0] wr_col_i,
  input  logic [7:0]    wr_char_i,
  input  logic          force_refresh_i,
  output logic          lcd_rs_o,
  output logic          lcd_rw_o,
  output logic          lcd_e_o,
  output logic [7:0]    lcd_data_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  localparam int unsigned MaxSE  = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
  localparam int unsigned MaxCyc = (MaxSE > WAIT_CYC) ? MaxSE : WAIT_CYC;
  localparam int unsigned TW     = $clog2(MaxCyc + 1);

  typedef enum logic [2:0] {StIdle, StSelect, StAddr, StChar, StNext} state_e;
  typedef enum logic [1:0] {PhSetup, PhStrobe, PhHold} phase_e;

  state_e        state_q;
  phase_e        phase_q;
  logic [TW-1:0] cnt_q;
  logic [LW-1:0] line_q, ptr_q, sel_line;
  logic [CW-1:0] col_q, col_next;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [7:0]    fb_q [LINES][CHARS];
  logic          lcd_rs_q, lcd_e_q, frame_done_q;
  logic [7:0]    lcd_data_q;
  logic          wr_valid, xfer_more;
  int unsigned   idx;

  // Out-of-range coordinates are dropped entirely (no store, no dirty mark).
  assign wr_valid = wr_en_i && (32'(wr_line_i) < LINES) && (32'(wr_col_i) < CHARS);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned l = 0; l < LINES; l++) begin
        for (int unsigned c = 0; c < CHARS; c++) begin
          fb_q[l][c] <= 8'h20;
        end
      end
    end else if (wr_valid) begin
      fb_q[wr_line_i][wr_col_i] <= wr_char_i;
    end
  end

  // Clear from SELECT is applied first so that a concurrent write or force re-sets the bit.
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == StSelect) dirty_d[sel_line] = 1'b0;
    if (force_refresh_i)     dirty_d = '1;
    if (wr_valid)            dirty_d[wr_line_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) dirty_q <= '1;
    else         dirty_q <= dirty_d;
  end

  // First dirty line at or after ptr_q with wrap; the smallest offset is assigned last and wins.
  always_comb begin
    sel_line = ptr_q;
    idx      = 0;
    for (int unsigned k = 0; k < LINES; k++) begin
      idx = 32'(ptr_q) + (LINES - 1 - k);
      if (idx >= LINES) idx = idx - LINES;
      if (dirty_q[LW'(idx)]) sel_line = LW'(idx);
    end
  end

  assign col_next  = (state_q == StAddr) ? '0 : col_q + CW'(1);
  assign xfer_more = (state_q == StAddr) || (32'(col_q) < CHARS - 1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      phase_q      <= PhSetup;
      cnt_q        <= '0;
      line_q       <= '0;
      col_q        <= '0;
      ptr_q        <= '0;
      lcd_rs_q     <= 1'b0;
      lcd_e_q      <= 1'b0;
      lcd_data_q   <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (init_done_i && |dirty_q) state_q <= StSelect;
        end
        StSelect: begin
          line_q     <= sel_line;
          col_q      <= '0;
          state_q    <= StAddr;
          phase_q    <= PhSetup;
          cnt_q      <= '0;
          lcd_rs_q   <= 1'b0;
          lcd_data_q <= 8'h80 | {1'b0, LINE_STARTS[2'(sel_line)]};
        end
        StAddr, StChar: begin
          unique case (phase_q)
            PhSetup: begin
              if (cnt_q == TW'(SETUP_CYC - 1)) begin
                phase_q <= PhStrobe;
                cnt_q   <= '0;
                lcd_e_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + TW'(1);
              end
            end
            PhStrobe: begin
              if (cnt_q == TW'(E_CYC - 1)) begin
                phase_q <= PhHold;
                cnt_q   <= '0;
                lcd_e_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + TW'(1);
              end
            end
            PhHold: begin
              if (cnt_q == TW'(WAIT_CYC - 1)) begin
                cnt_q   <= '0;
                phase_q <= PhSetup;
                if (xfer_more) begin
                  // Character is sampled live from the buffer as its SETUP begins.
                  state_q    <= StChar;
                  col_q      <= col_next;
                  lcd_rs_q   <= 1'b1;
                  lcd_data_q <= fb_q[line_q][col_next];
                end else begin
                  state_q <= StNext;
                end
              end else begin
                cnt_q <= cnt_q + TW'(1);
              end
            end
            default: phase_q <= PhSetup;
          endcase
        end
        StNext: begin
          ptr_q <= (32'(line_q) == LINES - 1) ? '0 : line_q + LW'(1);
          // Dropping init_done lets the current line finish, then parks the engine.
          if (init_done_i && |dirty_q) begin
            state_q <= StSelect;
          end else begin
            state_q      <= StIdle;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lcd_rs_o     = lcd_rs_q;
  assign lcd_rw_o     = 1'b0;
  assign lcd_e_o      = lcd_e_q;
  assign lcd_data_o   = lcd_data_q;
  assign busy_o       = (state_q != StIdle);
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_refresher.sv
// Directed bench for lcd_frame_refresher: 2x4 main instance plus a 3x5 instance whose
// port widths can express out-of-range coordinates.
module tb_lcd_frame_refresher;

  logic       clk, reset, init_done;
  logic       wr_en, wr_line, force_refresh;
  logic [1:0] wr_col;
  logic [7:0] wr_char;
  logic       lcd_rs, lcd_rw, lcd_e, busy, frame_done;
  logic [7:0] lcd_data;

  logic       wr_en2, force2;
  logic [1:0] wr_line2;
  logic [2:0] wr_col2;
  logic [7:0] wr_char2;
  logic       lcd_rs2, lcd_rw2, lcd_e2, busy2, frame_done2;
  logic [7:0] lcd_data2;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int e_rise  = 0;
  int fd_cnt  = 0;
  logic e_prev = 1'b0;

  lcd_frame_refresher #(
    .LINES(2), .CHARS(4), .LINE_STARTS({7'h00, 7'h40, 7'h14, 7'h54}),
    .SETUP_CYC(1), .E_CYC(2), .WAIT_CYC(3)
  ) dut (
    .clk_i(clk), .reset_i(reset), .init_done_i(init_done), .wr_en_i(wr_en),
    .wr_line_i(wr_line), .wr_col_i(wr_col), .wr_char_i(wr_char),
    .force_refresh_i(force_refresh), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_e_o(lcd_e),
    .lcd_data_o(lcd_data), .busy_o(busy), .frame_done_o(frame_done)
  );

  lcd_frame_refresher #(
    .LINES(3), .CHARS(5), .SETUP_CYC(1), .E_CYC(2), .WAIT_CYC(3)
  ) dut2 (
    .clk_i(clk), .reset_i(reset), .init_done_i(init_done), .wr_en_i(wr_en2),
    .wr_line_i(wr_line2), .wr_col_i(wr_col2), .wr_char_i(wr_char2),
    .force_refresh_i(force2), .lcd_rs_o(lcd_rs2), .lcd_rw_o(lcd_rw2), .lcd_e_o(lcd_e2),
    .lcd_data_o(lcd_data2), .busy_o(busy2), .frame_done_o(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sample pre-edge values; the stimulus reads them only at negedges.
  always @(posedge clk) begin
    if (lcd_e === 1'b1 && e_prev === 1'b0) e_rise++;
    e_prev = lcd_e;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_e_high(input string tag);
    int n = 0;
    while (lcd_e !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check({tag, "_seen"}, {31'd0, lcd_e}, 32'd1);
  endtask

  task automatic wait_e_low();
    int n = 0;
    while (lcd_e === 1'b1 && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic expect_pulse(input string tag, input logic rs, input logic [7:0] d);
    int hw = 0;
    logic s_rs;
    logic [7:0] s_d;
    wait_e_high(tag);
    s_rs = lcd_rs;
    s_d  = lcd_data;
    while (lcd_e === 1'b1 && hw < 50) begin @(negedge clk); hw++; end
    check({tag, "_rs"}, {31'd0, s_rs}, {31'd0, rs});
    check({tag, "_data"}, {24'd0, s_d}, {24'd0, d});
    check({tag, "_ewidth"}, hw, 32'd2);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check(tag, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic write1(input logic line, input logic [1:0] col, input logic [7:0] ch);
    wr_en = 1'b1; wr_line = line; wr_col = col; wr_char = ch;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int e0, fd0, eh, bh, n;
    reset = 1'b1; init_done = 1'b0; wr_en = 1'b0; wr_line = 1'b0; wr_col = 2'd0;
    wr_char = 8'h00; force_refresh = 1'b0;
    wr_en2 = 1'b0; force2 = 1'b0; wr_line2 = 2'd0; wr_col2 = 3'd0; wr_char2 = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_e", {31'd0, lcd_e}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full frame after init: 80, 20 x4, C0, 20 x4
    e0 = e_rise; fd0 = fd_cnt;
    init_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_pulse($sformatf("frame1_p%0d", i), !(i == 0 || i == 5),
                   (i == 0) ? 8'h80 : (i == 5) ? 8'hC0 : 8'h20);
    end
    wait_idle("frame1_idle");
    check("frame1_epulses", e_rise - e0, 32'd10);
    check("frame1_fd", fd_cnt - fd0, 32'd1);

    // Idle write to line 1 col 2 redraws only line 1
    e0 = e_rise; fd0 = fd_cnt;
    write1(1'b1, 2'd2, 8'h41);
    expect_pulse("iw_p0", 1'b0, 8'hC0);
    expect_pulse("iw_p1", 1'b1, 8'h20);
    expect_pulse("iw_p2", 1'b1, 8'h20);
    expect_pulse("iw_p3", 1'b1, 8'h41);
    expect_pulse("iw_p4", 1'b1, 8'h20);
    wait_idle("iw_idle");
    check("iw_epulses", e_rise - e0, 32'd5);
    check("iw_fd", fd_cnt - fd0, 32'd1);

    // Out-of-range writes on the 3x5 instance are ignored
    n = 0;
    while (busy2 !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    check("oor_pre_idle", {31'd0, busy2}, 32'd0);
    wr_en2 = 1'b1; wr_line2 = 2'd1; wr_col2 = 3'd5; wr_char2 = 8'h55;
    @(negedge clk);
    wr_line2 = 2'd3; wr_col2 = 3'd0;
    @(negedge clk);
    wr_en2 = 1'b0;
    eh = 0; bh = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lcd_e2 !== 1'b0) eh++;
      if (busy2 !== 1'b0) bh++;
    end
    check("oor_e_quiet", eh, 32'd0);
    check("oor_busy_quiet", bh, 32'd0);
    wr_en2 = 1'b1; wr_line2 = 2'd2; wr_col2 = 3'd4;
    @(negedge clk);
    wr_en2 = 1'b0;
    n = 0;
    while (busy2 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("inrange_starts", {31'd0, busy2}, 32'd1);

    // Same-line write during line 0 col 1 strobe forces a redraw of line 0
    fd0 = fd_cnt;
    write1(1'b0, 2'd0, 8'h31);
    expect_pulse("ml_p0", 1'b0, 8'h80);
    expect_pulse("ml_p1", 1'b1, 8'h31);
    wait_e_high("ml_p2");
    check("ml_p2_data", {24'd0, lcd_data}, 32'h20);
    write1(1'b0, 2'd0, 8'h5A);
    wait_e_low();
    expect_pulse("ml_p3", 1'b1, 8'h20);
    expect_pulse("ml_p4", 1'b1, 8'h20);
    check("ml_no_early_fd", fd_cnt - fd0, 32'd0);
    expect_pulse("ml_r0", 1'b0, 8'h80);
    expect_pulse("ml_r1", 1'b1, 8'h5A);
    expect_pulse("ml_r2", 1'b1, 8'h20);
    expect_pulse("ml_r3", 1'b1, 8'h20);
    expect_pulse("ml_r4", 1'b1, 8'h20);
    wait_idle("ml_idle");
    check("ml_fd", fd_cnt - fd0, 32'd1);

    // Reset while E is high
    force_refresh = 1'b1;
    @(negedge clk);
    force_refresh = 1'b0;
    wait_e_high("rstmid");
    reset = 1'b1; init_done = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_e", {31'd0, lcd_e}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_data", {24'd0, lcd_data}, 32'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // init_done low: writes to line 0 only, bus stays quiet
    eh = 0; bh = 0;
    for (int i = 0; i < 50; i++) begin
      wr_en = 1'b1; wr_line = 1'b0; wr_col = 2'(i % 4); wr_char = 8'(8'h30 + i);
      @(negedge clk);
      if (lcd_e !== 1'b0) eh++;
      if (busy !== 1'b0) bh++;
    end
    wr_en = 1'b0;
    check("held_e_quiet", eh, 32'd0);
    check("held_busy_quiet", bh, 32'd0);

    // Line 1 is drawn too (dirty reset to all 1) and shows spaces (buffer reset)
    fd0 = fd_cnt;
    init_done = 1'b1;
    expect_pulse("hf_p0", 1'b0, 8'h80);
    expect_pulse("hf_p1", 1'b1, 8'h60);
    expect_pulse("hf_p2", 1'b1, 8'h61);
    expect_pulse("hf_p3", 1'b1, 8'h5E);
    expect_pulse("hf_p4", 1'b1, 8'h5F);
    expect_pulse("hf_p5", 1'b0, 8'hC0);
    expect_pulse("hf_p6", 1'b1, 8'h20);
    expect_pulse("hf_p7", 1'b1, 8'h20);
    expect_pulse("hf_p8", 1'b1, 8'h20);
    expect_pulse("hf_p9", 1'b1, 8'h20);
    wait_idle("hf_idle");
    check("hf_fd", fd_cnt - fd0, 32'd1);
    check("hf_rw", {31'd0, lcd_rw}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
